// File: rtl/led_mode_scheduler.sv
// Shares one 8-bit LED bank between NUM_MODES pattern drivers, switching owner on a
// debounced button press or a dwell timer, with a dark gap and driver reset per switch.
module led_mode_scheduler #(
  parameter int NUM_MODES       = 4,
  parameter int SEL_W           = 2,
  parameter int DWELL_CYCLES    = 6000,
  parameter int BLANK_CYCLES    = 50,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_raw,
  input  logic                   auto_en,
  input  logic [NUM_MODES*8-1:0] mode_leds,
  output logic [7:0]             led_out,
  output logic [SEL_W-1:0]       mode_sel,
  output logic [NUM_MODES-1:0]   drv_rst_n,
  output logic                   switching
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0] BLANK_LAST = BL_W'(BLANK_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_MODES - 1);

  typedef enum logic {BLANK, RUN} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   db_level_q, db_level_d;
  logic                   next_req_q, next_req_d;
  logic [BL_W-1:0]        blank_cnt_q, blank_cnt_d;
  logic [DW_W-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [7:0]             led_q, led_d;
  logic [NUM_MODES-1:0]   drv_q, drv_d;
  logic                   switching_q, switching_d;

  logic [7:0]             sel_slice;
  logic [NUM_MODES-1:0]   sel_onehot;
  logic                   advance;

  // A level is accepted only after it has differed from the accepted one for DEBOUNCE_CYCLES edges.
  always_comb begin
    sync_d     = {sync_q[0], btn_raw};
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    next_req_d = 1'b0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync_q[1];
        next_req_d = sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Unused encodings match no driver, giving a dark bank and no released reset.
  always_comb begin
    sel_slice  = '0;
    sel_onehot = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_slice     = mode_leds[8*k +: 8];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    sel_d       = sel_q;
    led_d       = '0;
    drv_d       = '0;
    switching_d = 1'b1;
    advance     = 1'b0;
    case (state_q)
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          state_d     = RUN;
          blank_cnt_d = '0;
          dwell_cnt_d = '0;
          drv_d       = sel_onehot;
          switching_d = 1'b0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      RUN: begin
        led_d       = sel_slice;
        drv_d       = sel_onehot;
        switching_d = 1'b0;
        if (auto_en) begin
          dwell_cnt_d = dwell_cnt_q + 1'b1;
        end
        advance = next_req_q || (auto_en && (dwell_cnt_q == DWELL_LAST));
        if (advance) begin
          state_d     = BLANK;
          sel_d       = (sel_q >= SEL_LAST) ? '0 : sel_q + 1'b1;
          dwell_cnt_d = '0;
          led_d       = '0;
          drv_d       = '0;
          switching_d = 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BLANK;
      sync_q      <= '0;
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      next_req_q  <= 1'b0;
      blank_cnt_q <= '0;
      dwell_cnt_q <= '0;
      sel_q       <= '0;
      led_q       <= '0;
      drv_q       <= '0;
      switching_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      next_req_q  <= next_req_d;
      blank_cnt_q <= blank_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      sel_q       <= sel_d;
      led_q       <= led_d;
      drv_q       <= drv_d;
      switching_q <= switching_d;
    end
  end

  assign led_out   = led_q;
  assign mode_sel  = sel_q;
  assign drv_rst_n = drv_q;
  assign switching = switching_q;

endmodule
